// File: rtl/cacheline_adaptor.sv
// Purpose: bridges whole-line cache fills/writebacks onto a beat-serial memory burst port.
// Latency: request edge T -> read_o/write_o at T+1 -> resp_o at T+5 with resp_i high every beat.
// Backpressure: beats advance only on resp_i; gaps in resp_i stall the burst without losing data.
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i
);

  localparam int NB    = LINE_W / BURST_W;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int OFS_W = $clog2(LINE_W / 8);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NB - 1);
  // Clears the byte-offset-within-line bits so memory always sees a line-aligned address.
  localparam logic [31:0]      LINE_MASK = ~((32'd1 << OFS_W) - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  beat_cnt;
  logic [LINE_W-1:0] wr_line;

  // Transaction FSM: accepts requests, counts beats, fills line_o and produces the resp_o pulse.
  // DONE evaluates requests exactly like IDLE on its way out, so a request held high
  // through DONE restarts immediately and read_o/write_o drop for only that one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      wr_line   <= '0;
      address_o <= '0;
      line_o    <= '0;
      resp_o    <= 1'b0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          resp_o   <= 1'b0;
          read_o   <= 1'b0;
          write_o  <= 1'b0;
          beat_cnt <= '0;
          if (write_i) begin
            // Writeback wins when both requests arrive together.
            state     <= WRITE;
            write_o   <= 1'b1;
            address_o <= address_i & LINE_MASK;
            wr_line   <= line_i;
          end else if (read_i) begin
            state     <= READ;
            read_o    <= 1'b1;
            address_o <= address_i & LINE_MASK;
          end else begin
            state     <= IDLE;
          end
        end

        READ: begin
          if (resp_i) begin
            line_o[int'(beat_cnt)*BURST_W +: BURST_W] <= burst_i;
            if (beat_cnt == LAST_BEAT) begin
              state  <= DONE;
              read_o <= 1'b0;
              resp_o <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        WRITE: begin
          if (resp_i) begin
            if (beat_cnt == LAST_BEAT) begin
              state   <= DONE;
              write_o <= 1'b0;
              resp_o  <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Present the current writeback beat straight from the counter; quiet outside WRITE.
  always_comb begin
    burst_o = '0;
    if (state == WRITE) begin
      burst_o = wr_line[int'(beat_cnt)*BURST_W +: BURST_W];
    end
  end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have parameter LINE_W, default 256, cache line width in bits.
REQ-002 SHALL have parameter BURST_W, default 64, memory beat width in bits; beats per line NB = LINE_W/BURST_W (4 at defaults).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port address_i  input  32  line address from cache.
REQ-006 SHALL have port read_i  input  1  line-fill request from cache.
REQ-007 SHALL have port write_i  input  1  line-writeback request from cache.
REQ-008 SHALL have port line_i  input  LINE_W  writeback data from cache.
REQ-009 SHALL have port line_o  output  LINE_W  fill data to cache.
REQ-010 SHALL have port resp_o  output  1  one-cycle completion pulse to cache.
REQ-011 SHALL have port address_o  output  32  burst address to memory.
REQ-012 SHALL have port read_o  output  1  burst read request to memory.
REQ-013 SHALL have port write_o  output  1  burst write request to memory.
REQ-014 SHALL have port burst_o  output  BURST_W  write beat to memory.
REQ-015 SHALL have port burst_i  input  BURST_W  read beat from memory.
REQ-016 SHALL have port resp_i  input  1  memory beat-valid/beat-accepted strobe.

Function
REQ-017 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-018 In IDLE, write_i=1 at a rising edge SHALL latch address_i and line_i and go to WRITE; write has priority if read_i and write_i are both 1.
REQ-019 In IDLE, read_i=1 with write_i=0 SHALL latch address_i and go to READ.
REQ-020 address_o SHALL equal the latched address with bits [log2(LINE_W/8)-1:0] forced to 0, and SHALL stay stable for the whole transaction.
REQ-021 read_o SHALL be 1 exactly while in READ; write_o SHALL be 1 exactly while in WRITE; both registered, never both 1.
REQ-022 A 2-bit beat counter SHALL reset to 0 on entry to READ/WRITE and advance only on cycles with resp_i=1; gaps in resp_i SHALL stall without loss.
REQ-023 In READ, each resp_i=1 cycle SHALL capture burst_i into line slice [BURST_W*k +: BURST_W], k = beat counter; beat 0 is the least-significant slice.
REQ-024 In WRITE, burst_o SHALL present latched line slice k combinationally from the counter; the beat is retired on resp_i=1.
REQ-025 On the resp_i cycle retiring beat NB-1, the FSM SHALL go to DONE; read_o/write_o SHALL be 0 from the next cycle.
REQ-026 In DONE, resp_o SHALL be 1 for exactly one cycle, line_o SHALL hold the assembled line (reads), then FSM returns to IDLE.
REQ-027 line_o SHALL hold its value until the next read's first beat; burst_o SHALL be 0 outside WRITE.
REQ-028 read_i/write_i SHALL be ignored outside IDLE; a request held high through DONE SHALL start a new transaction from IDLE on the following edge.
REQ-029 resp_i SHALL be ignored in IDLE and DONE.
REQ-030 Minimum latency: request edge T -> read_o/write_o at T+1 -> with resp_i high T+1..T+4, resp_o at T+5.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, counter 0, resp_o/read_o/write_o 0, address_o 0, line_o 0, burst_o 0, regardless of clk.
REQ-032 Reset mid-transaction SHALL abort it with no resp_o; first request after rst_n rises is serviced normally.

Verification
REQ-033 Read: address_i=0x0000_1234, read_i pulse; resp_i 4 cycles with beats 0x11..,0x22..,0x33..,0x44.. -> address_o=0x0000_1220, line_o={44..,33..,22..,11..}, resp_o one cycle at T+5.
REQ-034 Write: line_i=256'h0123...CDEF, write_i -> burst_o shows line_i[63:0],[127:64],[191:128],[255:192] on successive resp_i cycles; write_o drops after 4th; one resp_o.
REQ-035 Stalled read: resp_i pattern 1,0,0,1,1,0,1 -> exactly 4 beats captured in order, resp_o one cycle after last beat, read_o held through gaps.
REQ-036 Simultaneous read_i=write_i=1 in IDLE -> write_o asserted, read_o stays 0.
REQ-037 rst_n low after beat 2 of a read -> outputs 0 asynchronously, no resp_o; subsequent read completes correctly.
REQ-038 Back-to-back: read_i held high across DONE -> second transaction starts, read_o low exactly one cycle between them.
